// File: rtl/cory_s2p_flex.sv
// rtl/cory_s2p_flex.sv - serial-to-parallel packer, N-bit beats into N*R-bit words with flush and lane mask
// Optional build macro CORY_S2P_FLEX_MSB_FIRST_EN places the first beat in the most-significant lane.
module cory_s2p_flex #(
   parameter int N  = 8,
   parameter int R  = 4,
   parameter int Z  = N * R,
   parameter int BS = (R <= 2) ? 1 : $clog2(R)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_a_v,
   input  logic [N-1:0]  i_a_d,
   input  logic          i_a_l,
   output logic          o_a_r,
   output logic          o_z_v,
   output logic [Z-1:0]  o_z_d,
   output logic [R-1:0]  o_z_m,
   output logic [BS-1:0] o_z_s,
   input  logic          i_z_r
);

   logic [Z-1:0]  acc_q;
   logic [Z-1:0]  acc_nxt;
   logic [R-1:0]  msk_q;
   logic [R-1:0]  msk_nxt;
   logic [R-1:0]  lane_sel;
   logic [BS-1:0] cnt_q;
   logic          acc_a;
   logic          xfr_z;
   logic          last_lane;
   logic          comp;

   // Ready depends only on the output register, so the producer never sees a combinational loop.
   assign o_a_r     = !o_z_v | i_z_r;
   assign acc_a     = i_a_v & o_a_r;
   assign xfr_z     = o_z_v & i_z_r;
   assign last_lane = (cnt_q == BS'(R - 1));
   assign comp      = acc_a & (last_lane | i_a_l);

   always_comb begin
      lane_sel = '0;
      for (int k = 0; k < R; k++) begin
`ifdef CORY_S2P_FLEX_MSB_FIRST_EN
         lane_sel[R-1-k] = (cnt_q == BS'(k));
`else
         lane_sel[k] = (cnt_q == BS'(k));
`endif
      end
   end

   // Accumulator including the beat being accepted this cycle; this is what a completing word loads.
   always_comb begin
      acc_nxt = acc_q;
      msk_nxt = msk_q;
      if (acc_a) begin
         for (int k = 0; k < R; k++) begin
            if (lane_sel[k]) begin
               acc_nxt[k*N +: N] = i_a_d;
               msk_nxt[k]        = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         msk_q <= '0;
         cnt_q <= '0;
      end else if (comp) begin
         acc_q <= '0;
         msk_q <= '0;
         cnt_q <= '0;
      end else if (acc_a) begin
         acc_q <= acc_nxt;
         msk_q <= msk_nxt;
         cnt_q <= cnt_q + BS'(1);
      end
   end

   // A completing beat wins over a transfer, so a drain and a reload on the same edge keep o_z_v high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         o_z_v <= 1'b0;
         o_z_d <= '0;
         o_z_m <= '0;
         o_z_s <= '0;
      end else if (comp) begin
         o_z_v <= 1'b1;
         o_z_d <= acc_nxt;
         o_z_m <= msk_nxt;
         o_z_s <= cnt_q;
      end else if (xfr_z) begin
         o_z_v <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cory_s2p_flex.sv
// tb/tb_cory_s2p_flex.sv - directed bench for cory_s2p_flex, R=4 and R=3 instances
// Expectations follow CORY_S2P_FLEX_MSB_FIRST_EN when it is defined.
module tb_cory_s2p_flex;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        a_v4 = 1'b0;
   logic [7:0]  a_d4 = '0;
   logic        a_l4 = 1'b0;
   logic        a_r4;
   logic        z_v4;
   logic [31:0] z_d4;
   logic [3:0]  z_m4;
   logic [1:0]  z_s4;
   logic        z_r4 = 1'b1;

   logic        a_v3 = 1'b0;
   logic [7:0]  a_d3 = '0;
   logic        a_l3 = 1'b0;
   logic        a_r3;
   logic        z_v3;
   logic [23:0] z_d3;
   logic [2:0]  z_m3;
   logic [1:0]  z_s3;
   logic        z_r3 = 1'b1;

   int n_assert = 0;
   int n_fail   = 0;
   int xfr_cnt  = 0;

`ifdef CORY_S2P_FLEX_MSB_FIRST_EN
   localparam logic [31:0] E_FULL = 32'h11223344;
   localparam logic [31:0] E_FL   = 32'hA1A20000;
   localparam logic [3:0]  M_FL   = 4'b1100;
   localparam logic [31:0] E_SGL  = 32'h5C000000;
   localparam logic [3:0]  M_SGL  = 4'b1000;
   localparam logic [31:0] E_BP1  = 32'h01020304;
   localparam logic [31:0] E_BP2  = 32'h05060708;
   localparam logic [31:0] E_B2A  = 32'h71000000;
   localparam logic [31:0] E_B2B  = 32'h72000000;
   localparam logic [31:0] E_LF   = 32'h81828384;
   localparam logic [31:0] E_RST  = 32'h10203040;
`else
   localparam logic [31:0] E_FULL = 32'h44332211;
   localparam logic [31:0] E_FL   = 32'h0000A2A1;
   localparam logic [3:0]  M_FL   = 4'b0011;
   localparam logic [31:0] E_SGL  = 32'h0000005C;
   localparam logic [3:0]  M_SGL  = 4'b0001;
   localparam logic [31:0] E_BP1  = 32'h04030201;
   localparam logic [31:0] E_BP2  = 32'h08070605;
   localparam logic [31:0] E_B2A  = 32'h00000071;
   localparam logic [31:0] E_B2B  = 32'h00000072;
   localparam logic [31:0] E_LF   = 32'h84838281;
   localparam logic [31:0] E_RST  = 32'h40302010;
`endif

   cory_s2p_flex #(.N(8), .R(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n),
      .i_a_v(a_v4), .i_a_d(a_d4), .i_a_l(a_l4), .o_a_r(a_r4),
      .o_z_v(z_v4), .o_z_d(z_d4), .o_z_m(z_m4), .o_z_s(z_s4), .i_z_r(z_r4)
   );

   cory_s2p_flex #(.N(8), .R(3)) u_dut3 (
      .clk(clk), .reset_n(reset_n),
      .i_a_v(a_v3), .i_a_d(a_d3), .i_a_l(a_l3), .o_a_r(a_r3),
      .o_z_v(z_v3), .o_z_d(z_d3), .o_z_m(z_m3), .o_z_s(z_s3), .i_z_r(z_r3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset_n && z_v4 && z_r4) xfr_cnt++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step4(input logic [7:0] d, input logic l);
      a_v4 = 1'b1;
      a_d4 = d;
      a_l4 = l;
      @(negedge clk);
      a_v4 = 1'b0;
      a_l4 = 1'b0;
   endtask

   task automatic idle4();
      a_v4 = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [23:0] w3(input int i);
`ifdef CORY_S2P_FLEX_MSB_FIRST_EN
      return {8'(i - 2), 8'(i - 1), 8'(i)};
`else
      return {8'(i), 8'(i - 1), 8'(i - 2)};
`endif
   endfunction

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_v", z_v4, 0);
      chk("rst_d", z_d4, 0);
      chk("rst_m", z_m4, 0);
      chk("rst_s", z_s4, 0);
      chk("rst_ar", a_r4, 1);
      reset_n = 1'b1;
      @(negedge clk);

      // full word
      step4(8'h11, 0);
      step4(8'h22, 0);
      step4(8'h33, 0);
      chk("full_lat", z_v4, 0);
      step4(8'h44, 0);
      chk("full_v", z_v4, 1);
      chk("full_d", z_d4, E_FULL);
      chk("full_m", z_m4, 4'b1111);
      chk("full_s", z_s4, 3);

      // early flush, then single-beat flush starting at lane 0
      step4(8'hA1, 0);
      chk("fl_drain", z_v4, 0);
      step4(8'hA2, 1);
      chk("fl_v", z_v4, 1);
      chk("fl_d", z_d4, E_FL);
      chk("fl_m", z_m4, M_FL);
      chk("fl_s", z_s4, 1);
      step4(8'h5C, 1);
      chk("sgl_v", z_v4, 1);
      chk("sgl_d", z_d4, E_SGL);
      chk("sgl_m", z_m4, M_SGL);
      chk("sgl_s", z_s4, 0);

      // backpressure
      step4(8'h01, 0);
      z_r4 = 1'b0;
      step4(8'h02, 0);
      step4(8'h03, 0);
      step4(8'h04, 0);
      chk("bp_v", z_v4, 1);
      a_v4 = 1'b1;
      a_d4 = 8'h05;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_ar", a_r4, 0);
         chk("bp_hold_v", z_v4, 1);
         chk("bp_hold_d", z_d4, E_BP1);
         chk("bp_hold_m", z_m4, 4'b1111);
         chk("bp_hold_s", z_s4, 3);
      end
      a_v4 = 1'b0;
      chk("bp_xfr_before", xfr_cnt, 3);
      z_r4 = 1'b1;
      step4(8'h05, 0);
      chk("bp_release_v", z_v4, 0);
      chk("bp_xfr_once", xfr_cnt, 4);
      step4(8'h06, 0);
      step4(8'h07, 0);
      step4(8'h08, 0);
      chk("bp_next_v", z_v4, 1);
      chk("bp_next_d", z_d4, E_BP2);
      idle4();
      chk("bp_xfr_total", xfr_cnt, 5);
      chk("bp_idle_v", z_v4, 0);

      // back-to-back single-beat words: drain and reload on the same edge
      step4(8'h71, 1);
      chk("b2b_a_d", z_d4, E_B2A);
      step4(8'h72, 1);
      chk("b2b_b_v", z_v4, 1);
      chk("b2b_b_d", z_d4, E_B2B);
      chk("b2b_xfr", xfr_cnt, 6);

      // last on the final lane gives exactly one word
      step4(8'h81, 0);
      step4(8'h82, 0);
      step4(8'h83, 0);
      step4(8'h84, 1);
      chk("lf_d", z_d4, E_LF);
      chk("lf_s", z_s4, 3);
      idle4();
      chk("lf_no_extra", z_v4, 0);

      // R=3 streaming
      for (int i = 1; i <= 9; i++) begin
         a_v3 = 1'b1;
         a_d3 = 8'(i);
         @(negedge clk);
         chk("r3_ar", a_r3, 1);
         if (i % 3 == 0) begin
            chk("r3_v", z_v3, 1);
            chk("r3_d", z_d3, w3(i));
            chk("r3_m", z_m3, 3'b111);
            chk("r3_s", z_s3, 2);
         end else if (i > 3) begin
            chk("r3_gap", z_v3, 0);
         end
      end
      a_v3 = 1'b0;

      // reset with a held word
      z_r4 = 1'b0;
      step4(8'hC1, 0);
      step4(8'hC2, 0);
      step4(8'hC3, 0);
      step4(8'hC4, 0);
      chk("rh_v", z_v4, 1);
      reset_n = 1'b0;
      #1;
      chk("rh_async_v", z_v4, 0);
      chk("rh_async_m", z_m4, 0);
      @(negedge clk);
      reset_n = 1'b1;
      z_r4 = 1'b1;

      // reset mid-fill
      step4(8'hE1, 0);
      step4(8'hE2, 0);
      reset_n = 1'b0;
      #1;
      chk("rm_async_v", z_v4, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rm_quiet", z_v4, 0);
      step4(8'h10, 0);
      step4(8'h20, 0);
      step4(8'h30, 0);
      chk("rm_lat", z_v4, 0);
      step4(8'h40, 0);
      chk("rm_v", z_v4, 1);
      chk("rm_d", z_d4, E_RST);
      chk("rm_m", z_m4, 4'b1111);
      idle4();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cory_s2p_flex.md
Name: cory_s2p_flex

Overview:
- Parametrised serial-to-parallel packer: collects N-bit beats from a valid/ready stream into one Z = N*R-bit word.
- Successor to the fixed-ratio packer. Differences:
  - Any ratio R from 2 to 16, including non-powers of two.
  - Early flush of a partial word on an input last flag.
  - Per-lane valid mask and lane count on the output.
- Built as one accumulator plus one output register, not a demux/flop/pack chain.
- Sits between narrow producers (bus or serial front-ends) and wide datapath consumers.

Parameters:
- N, 8, bits per beat (lane width).
- R, 4, lanes per output word; legal range 2..16; other values unsupported.
- Z, N*R, output data width (derived; do not override).
- BS, ceil(log2(R)) with minimum 1, width of lane count (derived).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- i_a_v  input  1  input beat valid
- i_a_d  input  N  input beat data
- i_a_l  input  1  last beat; closes the current word, qualified by i_a_v
- o_a_r  output  1  input ready
- o_z_v  output  1  output word valid
- o_z_d  output  Z  output word; lane k occupies bits [k*N +: N]
- o_z_m  output  R  lane mask; bit k set when lane k holds an accepted beat
- o_z_s  output  BS  number of valid lanes minus 1
- i_z_r  input  1  output ready

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, asynchronous assert, active-low. All state is cleared at reset.
- Reset values: o_z_v=0, o_z_d=0, o_z_m=0, o_z_s=0. Accumulator, lane counter cnt and lane mask all 0.
- Handshakes:
  - Input accept: acc_a = i_a_v & o_a_r.
  - Output transfer: xfr_z = o_z_v & i_z_r.
  - o_a_r = !o_z_v | i_z_r. It is purely a function of output-register state and i_z_r, never of i_a_v or i_a_l.
- On acc_a: i_a_d is written to accumulator lane cnt and mask bit cnt is set.
- Word completion: comp = acc_a & (cnt==R-1 | i_a_l). When comp is true:
  - Next-state accumulator (including the current beat) loads the output register: o_z_d, o_z_m, o_z_s=cnt.
  - o_z_v is set.
  - Accumulator and mask clear to 0 and cnt returns to 0.
- acc_a without comp: cnt increments by 1.
- Lanes not written in a flushed word read as 0 in o_z_d, with the matching o_z_m bits 0.
- Latency: o_z_v rises the cycle after the completing beat is accepted.
- Output register: o_z_d, o_z_m and o_z_s are held stable while o_z_v & !i_z_r.
- Simultaneous xfr_z and comp: the output register reloads with the new word and o_z_v stays 1, giving back-to-back words with no bubble.
- xfr_z without comp: o_z_v clears and o_z_d, o_z_m, o_z_s keep their stale values.
- Throughput: one beat per cycle while the sink is ready. The input stalls only while a held word is blocked (o_z_v=1, i_z_r=0).
- i_a_l with cnt==R-1: a single full word; no extra empty word is generated.
- i_a_l at cnt==0: a one-lane word with o_z_m bit 0 set and o_z_s=0.
- i_a_v low: no state change except output drain.
- Reset mid-fill or with a held word: the partial word and held word are discarded, with no output after reset until a new word completes.
- Arithmetic: cnt is BS bits and wraps only through the completion clear, never by overflow. Non-power-of-two R (e.g. 3, 5, 12) completes at cnt==R-1 exactly.

Optional Feature:
- Macro: CORY_S2P_FLEX_MSB_FIRST_EN.
- Defined: the first accepted beat goes to the most-significant lane. Lane k is placed at bits [(R-1-k)*N +: N] and the mask is bit-reversed to match: first beat sets o_z_m[R-1]. Flushed words are left-aligned, with unused low lanes 0.
- Undefined: the first beat is in lane 0 at the LSBs, as described above.
- Handshake, latency, o_z_s and all boundary behaviour are identical in both builds.

Test Plan:
- Full word (N=8, R=4, i_z_r=1): beats 0x11,0x22,0x33,0x44 -> one cycle after the 4th accept: o_z_v=1, o_z_d=0x44332211, o_z_m=4'b1111, o_z_s=3.
- Early flush (N=8, R=4): 0xA1, then 0xA2 with i_a_l=1 -> o_z_d=0x0000A2A1, o_z_m=4'b0011, o_z_s=1. The next word starts in lane 0.
- Single-beat flush (N=8, R=4): 0x5C with i_a_l=1 at cnt=0 -> o_z_d=0x0000005C, o_z_m=4'b0001, o_z_s=0.
- Backpressure (N=8, R=4): complete a word, then hold i_z_r=0 for 5 cycles -> o_a_r=0 and o_z_d/o_z_m/o_z_s stable throughout. On release, the held word transfers once and the following beats pack with no loss or duplication.
- Streaming, non-power-of-two ratio (N=8, R=3): i_a_v=1 and i_z_r=1 continuously, beats 0x01..0x09 -> words 0x030201, 0x060504, 0x090807, each with o_z_m=3'b111 and o_z_s=2. o_a_r stays 1 throughout.
- Reset mid-operation (N=8, R=4): accept 2 beats, pulse reset_n low -> o_z_v=0 immediately. Then beats 0x10,0x20,0x30,0x40 -> o_z_d=0x40302010, o_z_m=4'b1111. Repeat with CORY_S2P_FLEX_MSB_FIRST_EN defined -> o_z_d=0x10203040.
